// File: rtl/fib_call_ctrl_if.sv
// Bus bundle for fib_call_ctrl: argument stream, result stream
// and the Fibonacci core call port.
interface fib_call_ctrl_if #(
  parameter int N_WIDTH = 32,
  parameter int R_WIDTH = 64
);
  logic signed [N_WIDTH-1:0] i_n;
  logic                      i_valid;
  logic                      i_ready;
  logic signed [R_WIDTH-1:0] o_result;
  logic                      o_timeout;
  logic                      o_valid;
  logic                      o_ready;
  logic signed [N_WIDTH-1:0] fib_n;
  logic                      fib_req;
  logic                      fib_busy;
  logic signed [R_WIDTH-1:0] fib_return;

  modport master (
    input  i_n, i_valid,
    output i_ready,
    output o_result, o_timeout, o_valid,
    input  o_ready,
    output fib_n, fib_req,
    input  fib_busy, fib_return
  );

  modport slave (
    output i_n, i_valid,
    input  i_ready,
    input  o_result, o_timeout, o_valid,
    output o_ready,
    input  fib_n, fib_req,
    output fib_busy, fib_return
  );
endinterface

// File: rtl/fib_call_ctrl.sv
// Serialising call sequencer in front of the Fibonacci core.
// Optional watchdog abort: define FIB_CALL_TIMEOUT_EN.
module fib_call_ctrl #(
  parameter int N_WIDTH        = 32,
  parameter int R_WIDTH        = 64,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  fib_call_ctrl_if.master      bus,
  output logic [CNT_WIDTH-1:0] call_count
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_IDLE,
    REQ,
    WAIT_ACK,
    WAIT_DONE,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic signed [N_WIDTH-1:0] n_q, n_d;
  logic signed [R_WIDTH-1:0] res_q, res_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;

`ifdef FIB_CALL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIM =
    WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            to_q, to_d;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
`ifdef FIB_CALL_TIMEOUT_EN
    wd_d    = wd_q;
    to_d    = to_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          n_d     = bus.i_n;
          state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (!bus.fib_busy) state_d = REQ;
      end
      REQ: begin
        // busy rising under us means no req went out: retry
        state_d = bus.fib_busy ? WAIT_IDLE : WAIT_ACK;
`ifdef FIB_CALL_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      WAIT_ACK: begin
        if (bus.fib_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!bus.fib_busy) begin
          res_d   = bus.fib_return;
          cnt_d   = cnt_q + CNT_WIDTH'(1);
          state_d = RESP;
`ifdef FIB_CALL_TIMEOUT_EN
          to_d    = 1'b0;
`endif
        end
      end
      RESP: begin
        if (bus.o_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef FIB_CALL_TIMEOUT_EN
    if (state_q == WAIT_ACK || state_q == WAIT_DONE) begin
      wd_d = wd_q + WD_W'(1);
      if (wd_q == WD_LIM) begin
        res_d   = '0;
        to_d    = 1'b1;
        cnt_d   = cnt_q;
        state_d = RESP;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
`ifdef FIB_CALL_TIMEOUT_EN
      wd_q    <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
`ifdef FIB_CALL_TIMEOUT_EN
      wd_q    <= wd_d;
      to_q    <= to_d;
`endif
    end
  end

  assign bus.i_ready  = (state_q == IDLE) && !reset;
  assign bus.o_valid  = (state_q == RESP) && !reset;
  assign bus.fib_req  = (state_q == REQ) && !bus.fib_busy
                        && !reset;
  assign bus.fib_n    = n_q;
  assign bus.o_result = res_q;
  assign call_count   = cnt_q;
`ifdef FIB_CALL_TIMEOUT_EN
  assign bus.o_timeout = to_q;
`else
  assign bus.o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fib_call_ctrl.sv
// Bench for fib_call_ctrl: vector table plus scoreboard,
// with a behavioural Fibonacci core on the call port.
module tb_fib_call_ctrl;

  localparam int NW = 32;
  localparam int RW = 64;
  localparam int CW = 2;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          core_rst;
  logic          hang;
  logic [CW-1:0] call_count;

  fib_call_ctrl_if #(.N_WIDTH(NW), .R_WIDTH(RW)) bus ();

  fib_call_ctrl #(
    .N_WIDTH(NW),
    .R_WIDTH(RW),
    .TIMEOUT_CYCLES(TO),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .call_count(call_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name,
                     input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint fibf(input longint n);
    longint a, b, t;
    a = 0;
    b = 1;
    if (n <= 0) return 0;
    for (longint i = 1; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  // behavioural core: busy after reset, then busy for a call
  int              bcnt;
  logic signed [RW-1:0] pend;

  always @(posedge clk) begin
    if (core_rst) begin
      bus.fib_busy   <= 1'b1;
      bus.fib_return <= '0;
      bcnt           <= 12;
      pend           <= '0;
    end else if (bus.fib_busy) begin
      if (bcnt <= 1) begin
        if (!hang) begin
          bus.fib_busy   <= 1'b0;
          bus.fib_return <= pend;
        end
      end else begin
        bcnt <= bcnt - 1;
      end
    end else if (bus.fib_req) begin
      bus.fib_busy <= 1'b1;
      bcnt         <= 4 + int'(bus.fib_n[2:0]);
      pend         <= fibf(longint'(bus.fib_n));
    end
  end

  typedef struct {
    logic signed [RW-1:0] r;
    logic                 to;
    logic [CW-1:0]        cnt;
  } exp_t;

  exp_t                 q[$];
  exp_t                 e;
  exp_t                 g;
  logic signed [RW-1:0] exp_r;
  logic                 exp_to;
  logic [CW-1:0]        exp_cnt;
  int                   req_cnt;
  int                   acc_cyc;
  int                   req_cyc;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.i_valid && bus.i_ready) begin
        e.r    = exp_r;
        e.to   = exp_to;
        e.cnt  = exp_to ? exp_cnt : exp_cnt + 2'd1;
        exp_cnt = e.cnt;
        q.push_back(e);
        acc_cyc = cyc;
      end
      if (bus.fib_req) begin
        req_cnt++;
        req_cyc = cyc;
        chk("req_while_busy", bus.fib_busy, 0);
      end
      if (bus.o_valid && bus.o_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_resp", 1, 0);
        end else begin
          g = q.pop_front();
          chk("o_result", bus.o_result, g.r);
          chk("o_timeout", bus.o_timeout, g.to);
          chk("call_count", call_count, g.cnt);
          chk("req_pulses", req_cnt, 1);
        end
        req_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset    = 1'b1;
    core_rst = 1'b1;
    repeat (2) tick();
    reset    = 1'b0;
    core_rst = 1'b0;
    q.delete();
    exp_cnt  = '0;
    req_cnt  = 0;
  endtask

  task automatic send(input logic signed [NW-1:0] n,
                      input logic signed [RW-1:0] r,
                      input logic to);
    bit ok;
    tick();
    bus.i_n     = n;
    bus.i_valid = 1'b1;
    exp_r       = r;
    exp_to      = to;
    ok          = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (bus.i_valid && bus.i_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept", ok, 1);
    tick();
    bus.i_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (q.size() == 0 && !bus.o_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain", ok, 1);
  endtask

  typedef struct {
    logic signed [NW-1:0] n;
    logic signed [RW-1:0] r;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected done");
    $fatal(1);
  end

  initial begin
    int bad;
    bit ok;
    tbl[0] = '{n: 0,  r: 64'sd0};
    tbl[1] = '{n: 1,  r: 64'sd1};
    tbl[2] = '{n: -5, r: 64'sd0};
    tbl[3] = '{n: 92, r: 64'sd7540113804746346429};
    for (int i = 4; i < 9; i++) tbl[i] = '{n: 3, r: 64'sd2};

    reset       = 1'b1;
    core_rst    = 1'b1;
    hang        = 1'b0;
    bus.i_n     = '0;
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b1;
    exp_r       = '0;
    exp_to      = 1'b0;
    exp_cnt     = '0;
    req_cnt     = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_i_ready", bus.i_ready, 0);
    chk("rst_o_valid", bus.o_valid, 0);
    chk("rst_o_result", bus.o_result, 0);
    chk("rst_o_timeout", bus.o_timeout, 0);
    chk("rst_fib_req", bus.fib_req, 0);
    chk("rst_fib_n", bus.fib_n, 0);
    chk("rst_call_count", call_count, 0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    core_rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", bus.i_ready, 1);

    // call issued while the core is still busy from reset
    send(10, 64'sd55, 1'b0);
    @(negedge clk);
    chk("held_req", req_cnt, 0);
    chk("fib_n_latched", bus.fib_n, 10);
    drain();

    for (int i = 0; i < 9; i++) begin
      if (i == 4) do_reset();
      send(tbl[i].n, tbl[i].r, 1'b0);
      drain();
      if (i < 4) chk("req_latency", req_cyc - acc_cyc, 2);
    end
    chk("wrap_count", call_count, 1);

    // back-to-back with backpressure
    do_reset();
    bus.o_ready = 1'b0;
    send(20, 64'sd6765, 1'b0);
    ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (bus.o_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("bp_valid", ok, 1);
    tick();
    bus.i_n     = 30;
    bus.i_valid = 1'b1;
    exp_r       = 64'sd832040;
    exp_to      = 1'b0;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (!bus.o_valid || bus.o_result != 64'sd6765 ||
          bus.i_ready || call_count != 2'd1)
        bad++;
    end
    chk("bp_hold", bad, 0);
    tick();
    bus.o_ready = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (bus.i_valid && bus.i_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("bp_accept2", ok, 1);
    tick();
    bus.i_valid = 1'b0;
    drain();
    chk("bp_count", call_count, 2);

    // reset during WAIT_DONE, core keeps running
    send(40, 64'sd102334155, 1'b0);
    ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (req_cnt > 0 && bus.fib_busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("mid_busy", ok, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q.delete();
    exp_cnt = '0;
    req_cnt = 0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.o_valid) bad++;
    end
    chk("mid_no_valid", bad, 0);
    chk("mid_count", call_count, 0);
    send(5, 64'sd5, 1'b0);
    drain();

`ifdef FIB_CALL_TIMEOUT_EN
    hang = 1'b1;
    send(7, 64'sd0, 1'b1);
    drain();
    chk("to_count", call_count, 1);
    hang = 1'b0;
    send(2, 64'sd1, 1'b0);
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
